// File: rtl/c_arbiter_v2_spec.sv
// Packs a window of clauses onto the non-full queues in order and reports how many were taken; never stalls.
// Latency: 1 cycle with C_ARBITER_REG_OUT_EN defined, otherwise 0; the full_in bits are the only backpressure.
module c_arbiter_v2_spec #(
  parameter int OUTPUT_CNT      = 4,
  parameter int CLAUSE_WIDTH    = 2,
  parameter int ELEMENT_CNT     = 4,
  parameter int ELEMENT_BIT_CNT = $clog2(ELEMENT_CNT) + 1,
  parameter int CW              = CLAUSE_WIDTH * ELEMENT_BIT_CNT,
  parameter int AW              = $clog2(OUTPUT_CNT) + 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [OUTPUT_CNT-1:0][CW-1:0]    clause_in,
  input  logic [OUTPUT_CNT-1:0]            full_in,
  output logic [OUTPUT_CNT-1:0][CW-1:0]    clause_out,
  output logic [AW-1:0]                    clause_accept_out
);

  logic [OUTPUT_CNT-1:0][CW-1:0] arb_clause;
  logic [AW-1:0]                 arb_cnt;
  int                            k;

  // k counts the free queues seen so far, which is also the next window slot to hand out.
  always_comb begin
    arb_clause = '0;
    k          = 0;
    for (int q = 0; q < OUTPUT_CNT; q++) begin
      if (!full_in[q]) begin
        arb_clause[q] = clause_in[k];
        k             = k + 1;
      end
    end
    arb_cnt = AW'(k);
  end

`ifdef C_ARBITER_REG_OUT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      clause_out        <= '0;
      clause_accept_out <= '0;
    end else begin
      clause_out        <= arb_clause;
      clause_accept_out <= arb_cnt;
    end
  end
`else
  // Clock and reset only matter to the registered build.
  logic unused_clk_rst;
  assign unused_clk_rst    = clock ^ reset;
  assign clause_out        = arb_clause;
  assign clause_accept_out = arb_cnt;
`endif

endmodule

// File: tb/tb_c_arbiter_v2_spec.sv
// Directed table-driven bench for c_arbiter_v2_spec; adapts its reset and latency expectations to C_ARBITER_REG_OUT_EN.
module tb_c_arbiter_v2_spec;

  logic              clock = 1'b0;
  logic              reset;
  logic [3:0][5:0]   clause_in;
  logic [3:0]        full_in;
  logic [3:0][5:0]   clause_out;
  logic [2:0]        clause_accept_out;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  c_arbiter_v2_spec dut (
    .clock             (clock),
    .reset             (reset),
    .clause_in         (clause_in),
    .full_in           (full_in),
    .clause_out        (clause_out),
    .clause_accept_out (clause_accept_out)
  );

  typedef struct {
    logic [3:0]  full;
    logic [23:0] win;
    logic [23:0] eout;
    logic [2:0]  eacc;
  } vec_t;

  localparam logic [23:0] W1 = {6'd3, 6'd2, 6'd1, 6'd0};
  localparam logic [23:0] W3 = {6'd4, 6'd3, 6'd2, 6'd1};
  localparam logic [23:0] WX = {6'h3F, 6'h2A, 6'h15, 6'h00};

  vec_t tbl [10];

  task automatic check(input string name, input logic [23:0] eout, input logic [2:0] eacc);
    checks++;
    if (clause_out !== eout || clause_accept_out !== eacc) begin
      errors++;
      $display("FAIL %s: got clause_out=%h accept=%0d, expected clause_out=%h accept=%0d",
               name, clause_out, clause_accept_out, eout, eacc);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [23:0] prev_out;
  logic [2:0]  prev_acc;

  initial begin
    tbl[0] = '{4'b1001, W1, 24'h001000, 3'd2};
    tbl[1] = '{4'b0000, W3, W3,          3'd4};
    tbl[2] = '{4'b0110, W3, 24'h080001, 3'd2};
    tbl[3] = '{4'b1111, W3, 24'h000000, 3'd0};
    tbl[4] = '{4'b1110, W3, 24'h000001, 3'd1};
    tbl[5] = '{4'b0101, W3, 24'h080040, 3'd2};
    tbl[6] = '{4'b1000, W3, 24'h003081, 3'd3};
    tbl[7] = '{4'b0111, W3, 24'h040000, 3'd1};
    tbl[8] = '{4'b0000, WX, WX,          3'd4};
    tbl[9] = '{4'b1010, WX, 24'h015000, 3'd2};

    // Reset held with live inputs.
    reset     = 1'b1;
    clause_in = W1;
    full_in   = 4'b1001;
    step();
    step();
`ifdef C_ARBITER_REG_OUT_EN
    check("reset_hold", 24'h000000, 3'd0);
`else
    check("reset_ignored", 24'h001000, 3'd2);
`endif

    // Release: first result one edge later, then steady.
    reset = 1'b0;
    step();
    for (int c = 0; c < 10; c++) begin
      check($sformatf("stable_c%0d", c), 24'h001000, 3'd2);
      step();
    end
    prev_out = 24'h001000;
    prev_acc = 3'd2;

    for (int i = 0; i < 10; i++) begin
      full_in   = tbl[i].full;
      clause_in = tbl[i].win;
      #1;
`ifdef C_ARBITER_REG_OUT_EN
      check($sformatf("hold_vec%0d", i), prev_out, prev_acc);
`else
      check($sformatf("comb_vec%0d", i), tbl[i].eout, tbl[i].eacc);
`endif
      step();
      check($sformatf("vec%0d", i), tbl[i].eout, tbl[i].eacc);
      prev_out = tbl[i].eout;
      prev_acc = tbl[i].eacc;
    end

    // Single-cycle reset in the middle of a full-accept stream.
    full_in   = 4'b0000;
    clause_in = W3;
    step();
    check("pre_reset", W3, 3'd4);
    reset = 1'b1;
    step();
`ifdef C_ARBITER_REG_OUT_EN
    check("mid_reset", 24'h000000, 3'd0);
`else
    check("mid_reset_ignored", W3, 3'd4);
`endif
    reset = 1'b0;
    step();
    check("post_reset", W3, 3'd4);
    step();
    check("post_reset_hold", W3, 3'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
